// File: rtl/mips_pkg.sv
// Shared MIPS datapath definitions: register-file address width and type.
package mips_pkg;

    localparam int REG_ADDR_W = 5;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

endpackage

// File: rtl/mux_2to1_5bit_if.sv
// Bundle of the select-mux data signals.
// The master modport is the side that drives the selection inputs.
interface mux_2to1_5bit_if;
    import mips_pkg::*;

    logic      ctrl;
    reg_addr_t in1;
    reg_addr_t in2;
    reg_addr_t out;
    reg_addr_t out_q;
    logic      sel_q;

    modport master (
        output ctrl,
        output in1,
        output in2,
        input  out,
        input  out_q,
        input  sel_q
    );

    modport slave (
        input  ctrl,
        input  in1,
        input  in2,
        output out,
        output out_q,
        output sel_q
    );

endinterface

// File: rtl/mux2_core.sv
// Purely combinational 2:1 select. An unknown select yields all-X so that
// a floating control line is visible in simulation instead of being masked.
module mux2_core #(
    parameter int WIDTH = 5
) (
    input  logic             i_sel,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_y
);

    // Select i_a when i_sel = 0, i_b when i_sel = 1, X otherwise.
    always_comb begin
        o_y = 'x;
        case (i_sel)
            1'b0:    o_y = i_a;
            1'b1:    o_y = i_b;
            default: o_y = 'x;
        endcase
    end

endmodule

// File: rtl/mux_2to1_5bit.sv
// Destination-register select mux (rt vs rd) for the MIPS datapath.
// The port order is positional-compatible with older instances that only
// wire out, ctrl, in1 and in2; the registered copy is appended after them.
module mux_2to1_5bit
    import mips_pkg::*;
#(
    parameter int WIDTH = REG_ADDR_W
) (
    output logic [WIDTH-1:0] out,
    input  logic             ctrl,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             clk,
    input  logic             rst,
    output logic [WIDTH-1:0] out_q,
    output logic             sel_q
);

    logic [WIDTH-1:0] w_mux;
    logic [WIDTH-1:0] r_out_q;
    logic             r_sel_q;

    mux2_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .i_sel (ctrl),
        .i_a   (in1),
        .i_b   (in2),
        .o_y   (w_mux)
    );

    // Capture the selection and its select bit every edge; reset wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_q <= '0;
            r_sel_q <= 1'b0;
        end else begin
            r_out_q <= w_mux;
            r_sel_q <= ctrl;
        end
    end

    assign out   = w_mux;
    assign out_q = r_out_q;
    assign sel_q = r_sel_q;

endmodule

// File: tb/tb_mux_2to1_5bit.sv
// Directed and random checks of the combinational select and its
// registered copy.
module tb_mux_2to1_5bit;
    import mips_pkg::*;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    mux_2to1_5bit_if inf ();

    mux_2to1_5bit #(
        .WIDTH (REG_ADDR_W)
    ) dut (
        .out   (inf.out),
        .ctrl  (inf.ctrl),
        .in1   (inf.in1),
        .in2   (inf.in2),
        .clk   (clk),
        .rst   (rst),
        .out_q (inf.out_q),
        .sel_q (inf.sel_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_in(input logic c, input reg_addr_t a, input reg_addr_t b);
        inf.ctrl = c;
        inf.in1  = a;
        inf.in2  = b;
    endtask

    task automatic test_reset;
        @(negedge clk);
        rst = 1'b1;
        set_in(1'b1, 5'd7, 5'h1F);
        #1;
        checks++;
        if (inf.out !== 5'h1F) begin
            errors++;
            $display("FAIL reset_out_comb: got %0d want %0d", inf.out, 5'h1F);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if (inf.out_q !== 5'd0) begin
            errors++;
            $display("FAIL reset_out_q: got %0d want 0", inf.out_q);
        end
        checks++;
        if (inf.sel_q !== 1'b0) begin
            errors++;
            $display("FAIL reset_sel_q: got %0b want 0", inf.sel_q);
        end
        $display("reset: out=%0d out_q=%0d sel_q=%0b", inf.out, inf.out_q, inf.sel_q);
    endtask

    task automatic test_select;
        @(negedge clk);
        set_in(1'b0, 5'd3, 5'd17);
        #1;
        checks++;
        if (inf.out !== 5'd3) begin
            errors++;
            $display("FAIL select_in1: got %0d want 3", inf.out);
        end
        $display("select ctrl=0: out=%0d", inf.out);
        inf.ctrl = 1'b1;
        #1;
        checks++;
        if (inf.out !== 5'd17) begin
            errors++;
            $display("FAIL select_in2: got %0d want 17", inf.out);
        end
        @(posedge clk); #1;
        checks++;
        if (inf.out_q !== 5'd17 || inf.sel_q !== 1'b1) begin
            errors++;
            $display("FAIL select_reg: got out_q=%0d sel_q=%0b want 17/1", inf.out_q, inf.sel_q);
        end
        $display("select ctrl=1: out=%0d out_q=%0d sel_q=%0b", inf.out, inf.out_q, inf.sel_q);
    endtask

    task automatic test_mid_cycle_reset;
        // out_q holds 17 here; a reset pulse between edges must not clear it.
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (inf.out_q !== 5'd17) begin
            errors++;
            $display("FAIL midcycle_rst: got %0d want 17", inf.out_q);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (inf.out_q !== 5'd17) begin
            errors++;
            $display("FAIL midcycle_after: got %0d want 17", inf.out_q);
        end
        $display("midcycle reset pulse: out_q=%0d", inf.out_q);
    endtask

    task automatic test_boundary;
        @(negedge clk);
        set_in(1'b0, 5'h00, 5'h1F);
        #1;
        checks++;
        if (inf.out !== 5'h00) begin
            errors++;
            $display("FAIL boundary_zero: got %0d want 0", inf.out);
        end
        inf.ctrl = 1'b1;
        #1;
        checks++;
        if (inf.out !== 5'h1F) begin
            errors++;
            $display("FAIL boundary_max: got %0d want 31", inf.out);
        end
        @(posedge clk); #1;
        checks++;
        if (inf.out_q !== 5'h1F) begin
            errors++;
            $display("FAIL boundary_reg: got %0d want 31", inf.out_q);
        end
        $display("boundary: out=%0d out_q=%0d", inf.out, inf.out_q);
    endtask

    task automatic test_back_to_back;
        reg_addr_t prev;
        reg_addr_t want;
        prev = 5'h1F;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            set_in(i[0], 5'd10, 5'd21);
            want = i[0] ? 5'd21 : 5'd10;
            #1;
            checks++;
            if (inf.out !== want) begin
                errors++;
                $display("FAIL toggle_out[%0d]: got %0d want %0d", i, inf.out, want);
            end
            checks++;
            if (inf.out_q !== prev) begin
                errors++;
                $display("FAIL toggle_lag[%0d]: got %0d want %0d", i, inf.out_q, prev);
            end
            @(posedge clk); #1;
            checks++;
            if (inf.out_q !== want || inf.sel_q !== i[0]) begin
                errors++;
                $display("FAIL toggle_reg[%0d]: got %0d/%0b want %0d/%0b",
                         i, inf.out_q, inf.sel_q, want, i[0]);
            end
            $display("toggle %0d: ctrl=%0b out=%0d out_q=%0d", i, i[0], inf.out, inf.out_q);
            prev = want;
        end
    endtask

    task automatic test_random;
        logic      c;
        reg_addr_t a;
        reg_addr_t b;
        reg_addr_t want;
        int        bad;
        bad = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            c = 1'($urandom_range(1, 0));
            a = 5'($urandom_range(31, 0));
            b = 5'($urandom_range(31, 0));
            set_in(c, a, b);
            want = c ? b : a;
            #1;
            checks++;
            if (inf.out !== want) begin
                errors++; bad++;
                $display("FAIL rand_out[%0d]: got %0d want %0d", i, inf.out, want);
            end
            @(posedge clk); #1;
            checks++;
            if (inf.out_q !== want || inf.sel_q !== c) begin
                errors++; bad++;
                $display("FAIL rand_reg[%0d]: got %0d/%0b want %0d/%0b",
                         i, inf.out_q, inf.sel_q, want, c);
            end
        end
        $display("random: 200 cycles, %0d mismatched checks", bad);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst    = 1'b1;
        set_in(1'b0, 5'd0, 5'd0);
        test_reset();
        test_select();
        test_mid_cycle_reset();
        test_boundary();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
